// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side front end.
package fifo_pkg;
    typedef logic [31:0] word_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry circular store with push/pop/clear; head entry is read combinationally.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter type T = word_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  T           push_data,
    output T           head_data,
    output logic [1:0] count
);
    localparam int W = $bits(T);

    logic                  head_reg;
    logic                  tail_reg;
    logic [1:0]            count_reg;
    logic [1:0][W-1:0]     entries;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [W-1:0] entry_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entry_reg <= '0;
            end else if (!clear && push && (tail_reg == 1'(gi))) begin
                entry_reg <= push_data;
            end
        end

        assign entries[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else if (clear) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else begin
            // 1-bit pointers wrap on their own.
            if (push) tail_reg <= ~tail_reg;
            if (pop)  head_reg <= ~head_reg;
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    assign head_data = T'(entries[head_reg]);
    assign count     = count_reg;
endmodule

// File: rtl/fifo_reader.sv
// Read-side front end: issues FIFO reads, absorbs the 1-cycle read latency in a
// 2-entry skid buffer and presents a valid/ready stream with a flush for redirects.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter type T          = word_t,
    parameter int  SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    output logic       fifo_read_en,
    input  T           fifo_read_data,
    output logic       out_valid,
    output T           out_data,
    input  logic       out_ready,
    input  logic       flush,
    output logic [1:0] occupancy
);
    if (SKID_DEPTH != 2) begin : g_bad_depth
        $error("fifo_reader: SKID_DEPTH must be 2");
    end

    logic       pend_reg;
    logic       discard_reg;
    logic [1:0] count;
    logic       handshake;
    logic       pop;
    logic       capture;
    logic [2:0] reserved;

    assign out_valid = (count != 2'd0);
    assign handshake = out_valid && out_ready;
    assign pop       = handshake && !flush;

    // A slot is reserved at issue time, so capture can never overflow the buffer.
    assign reserved     = {1'b0, count} + {2'b00, pend_reg};
    assign fifo_read_en = reset && !fifo_empty && !flush
                          && (reserved < (3'd2 + {2'b00, handshake}));

    assign capture = pend_reg && !discard_reg && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg    <= 1'b0;
            discard_reg <= 1'b0;
        end else begin
            pend_reg    <= fifo_read_en;
            discard_reg <= flush && pend_reg;
        end
    end

    skid_buf2 #(.T(T)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (capture),
        .pop       (pop),
        .push_data (fifo_read_data),
        .head_data (out_data),
        .count     (count)
    );

    assign occupancy = count;
endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a queue-based FIFO model feeds the DUT and an
// expected-stream queue is popped by an independent monitor on every handshake.
module tb_fifo_reader;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_read_en;
    word_t      fifo_read_data = '0;
    logic       out_valid;
    word_t      out_data;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occupancy;

    always #5 clk = ~clk;

    fifo_reader #(.T(word_t), .SKID_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .flush          (flush),
        .occupancy      (occupancy)
    );

    word_t fifo_q[$];
    word_t exp_q[$];
    bit    inflight = 1'b0;
    word_t inflight_word = '0;
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    popped = 0;
    int    re_seen = 0;
    bit    last_re = 1'b0;
    bit    verbose = 1'b1;
    word_t last_pop = '0;
    int    first_re, first_ov, last_ov, ov_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares the DUT against the expected stream just after each falling edge.
    always @(negedge clk) begin : monitor
        int    sz;
        bit    exp_re;
        bit    hs;
        word_t w;
        #1;
        if (reset) begin
            sz = exp_q.size();
            hs = (sz != 0) && out_ready;
            exp_re = !fifo_empty && !flush && ((sz + int'(inflight) - int'(hs)) < 2);
            check("out_valid", 32'(out_valid), 32'(sz != 0));
            check("occupancy", 32'(occupancy), 32'(sz));
            check("read_en", 32'(fifo_read_en), 32'(exp_re));
            if (hs && !flush && out_valid) begin
                w = exp_q.pop_front();
                check("out_data", out_data, w);
                popped++;
                last_pop = out_data;
                if (verbose) $display("cycle %0d: pop data=0x%0h", cyc, out_data);
            end
        end
    end

    // One clock of stimulus plus the FIFO model's response to the DUT's read request.
    task automatic cycle(input bit fl, input bit rdy, input bit stall);
        bit    read_now;
        word_t nxt;
        @(negedge clk);
        cyc++;
        flush      = fl;
        out_ready  = rdy;
        fifo_empty = stall || (fifo_q.size() == 0);
        #2;
        read_now = 1'b0;
        nxt      = '0;
        last_re  = fifo_read_en;
        if (fifo_read_en) re_seen++;
        if (fifo_read_en && first_re < 0) first_re = cyc;
        if (out_valid) begin
            if (first_ov < 0) first_ov = cyc;
            last_ov = cyc;
            ov_cnt++;
        end
        if (reset) begin
            if (flush) exp_q.delete();
            else if (inflight) exp_q.push_back(inflight_word);
            if (fifo_read_en && fifo_q.size() > 0) begin
                nxt = fifo_q.pop_front();
                read_now = 1'b1;
            end
        end
        inflight      = read_now;
        inflight_word = nxt;
        @(posedge clk);
        #1;
        fifo_read_data = read_now ? nxt : word_t'($urandom);
    endtask

    task automatic clear_tracking();
        first_re = -1;
        first_ov = -1;
        last_ov  = -1;
        ov_cnt   = 0;
    endtask

    // Called at posedge+1; drops reset mid-cycle and checks the outputs clear before any edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("async_reset out_valid", 32'(out_valid), 32'd0);
        check("async_reset occupancy", 32'(occupancy), 32'd0);
        check("async_reset read_en", 32'(fifo_read_en), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        inflight = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int p0;
        clear_tracking();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset out_data", out_data, 32'h0);
        check("reset out_valid", 32'(out_valid), 32'd0);

        // Idle with an empty FIFO.
        repeat (10) cycle(1'b0, 1'b1, 1'b1);
        check("idle read_en count", 32'(re_seen), 32'd0);

        // Latency and back-to-back throughput.
        fifo_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        clear_tracking();
        p0 = popped;
        repeat (8) cycle(1'b0, 1'b1, 1'b0);
        check("first valid latency", 32'(first_ov - first_re), 32'd2);
        check("valid run length", 32'(ov_cnt), 32'd4);
        check("valid run contiguous", 32'(last_ov - first_ov), 32'd3);
        check("stream pops", 32'(popped - p0), 32'd4);
        check("stream last word", last_pop, 32'h44);

        // Backpressure: buffer saturates at two entries, nothing lost.
        for (int i = 0; i < 6; i++) fifo_q.push_back(32'h100 + 32'(i));
        p0 = popped;
        repeat (8) cycle(1'b0, 1'b0, 1'b0);
        check("bp occupancy", 32'(occupancy), 32'd2);
        check("bp read_en", 32'(fifo_read_en), 32'd0);
        repeat (14) cycle(1'b0, 1'b1, 1'b0);
        check("bp pops", 32'(popped - p0), 32'd6);
        check("bp last word", last_pop, 32'h105);

        // Flush while one entry is buffered and a read is in flight.
        fifo_q = '{32'h201};
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("flush setup occupancy", 32'(occupancy), 32'd1);
        fifo_q.push_back(32'h202);
        fifo_q.push_back(32'h203);
        cycle(1'b0, 1'b0, 1'b0);
        check("flush setup read_en", 32'(last_re), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check("flush occupancy", 32'(occupancy), 32'd0);
        p0 = popped;
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        check("post-flush pops", 32'(popped - p0), 32'd1);
        check("post-flush word", last_pop, 32'h203);

        // Asynchronous reset with two entries buffered.
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'h300 + 32'(i));
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        check("pre-reset occupancy", 32'(occupancy), 32'd2);
        do_reset();

        // Randomised traffic against the scoreboard.
        verbose = 1'b0;
        repeat (10000) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) fifo_q.push_back(word_t'($urandom));
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        end
        repeat (12) cycle(1'b0, 1'b1, 1'b0);
        check("drain occupancy", 32'(occupancy), 32'(exp_q.size()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side front end for the team's synchronous FIFO.
- Drives the FIFO's read_en, absorbs its one-cycle registered read latency into a 2-entry skid buffer, and presents a valid/ready stream to the consumer (decode/dispatch).
- Provides a flush input for pipeline redirect: it discards buffered and in-flight entries without touching the FIFO itself.
- Sustains one entry per cycle when the FIFO is non-empty and the consumer is ready.

Parameters:
- T, logic [31:0]: payload type; must match the FIFO's T.
- SKID_DEPTH, 2: local buffer entries. Fixed at 2; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  read request to the FIFO.
- fifo_read_data  in  $bits(T)  FIFO read_data; valid the cycle after an accepted read.
- out_valid  out  1  head entry valid.
- out_data  out  $bits(T)  head entry payload.
- out_ready  in  1  consumer accepts the head this cycle.
- flush  in  1  discard all buffered and in-flight entries.
- occupancy  out  2  entries currently held (0..2).

Behaviour:
- Reset (reset==0, async):
  - count=0, pend=0, discard=0, head pointer=0.
  - fifo_read_en=0, out_valid=0, occupancy=0, out_data='0.
  - Storage contents are don't-care.
- State:
  - 2-entry circular buffer with 1-bit head/tail pointers.
  - count[1:0].
  - pend: a read was issued last cycle.
  - discard: the in-flight read must be dropped.
- Pop: pop = out_valid && out_ready. out_valid = (count!=0). out_data = buf[head], driven combinationally from registered storage.
- Issue rule (combinational):
  - fifo_read_en = !fifo_empty && !flush && (count + pend - pop) < 2.
  - fifo_read_en is never asserted while fifo_empty=1.
- Capture: in the cycle with pend=1 && discard=0, write fifo_read_data into buf[tail], tail++, count++.
  - A capture never overflows, because the issue rule reserves the slot.
- Simultaneous capture and pop: count unchanged; head++ and tail++.
- Latency: data first presented with out_valid at cycle N+2 after fifo_empty falls at cycle N (read_en at N, FIFO registers at N+1, capture at N+1 edge, so visible at N+2 if empty is low at N).
- Throughput: with fifo_empty=0 and out_ready=1 held, out_valid=1 every cycle after fill, and fifo_read_en=1 every cycle.
- Backpressure: with out_ready=0, at most 2 entries are buffered. fifo_read_en drops once count+pend reaches 2, and no entry is lost.
- Flush:
  - On a cycle with flush=1, at the next edge: count=0, head=tail=0, pop ignored.
  - If pend=1 in that cycle, set discard=1 so the returning data is dropped at the next edge.
  - fifo_read_en=0 during flush.
  - Flush and capture in the same cycle: flush wins and the captured data is dropped.
- out_valid/out_data are stable while out_valid && !out_ready, except on flush.
- Wrap-around: pointers are 1 bit and wrap naturally.
- Reset mid-operation: all state is cleared immediately. Any FIFO read in flight is lost (the FIFO has its own reset).

Decomposition:
- Shared package (fifo_pkg): the default payload typedef (word_t = logic [31:0]) and localparam SKID_DEPTH=2, imported by both the FIFO and this block.
- Sub-module: optional skid_buf2 (2-entry circular store with push/pop/count). Otherwise the block stays single-module.

Test Plan:
- Reset then idle, fifo_empty=1 -> fifo_read_en=0, out_valid=0, occupancy=0 for 10 cycles.
- FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> out_data sequence 0x11..0x44 on 4 consecutive cycles; first out_valid exactly 2 cycles after the first read_en.
- Preload 6 words, out_ready=0 for 8 cycles then 1 -> occupancy saturates at 2, read_en deasserts, and all 6 words emerge in order with none dropped or duplicated.
- Flush asserted the cycle after read_en with 1 entry buffered -> next cycle occupancy=0; the in-flight word is discarded; the following read yields the next FIFO word.
- Reset pulled low mid-stream with 2 entries buffered -> out_valid=0 asynchronously, before the next edge.
- Random fifo_empty/out_ready/flush for 10k cycles against a scoreboard model -> order preserved, and no read_en while fifo_empty=1.
